// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM state type, legal parameter bounds and sizing helper for seq_pattern_detector
package seq_det_pkg;
  typedef enum logic [1:0] {UNCFG, FILL, ARMED} seq_det_state_e;
  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 32;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 32;
  function automatic int fill_w(input int pat_len);
    return $clog2(pat_len);
  endfunction
endpackage

// File: rtl/seq_pattern_detector_if.sv
// seq_pattern_detector_if: serial data, config and status bundle; counter signals only with SEQ_PATTERN_DETECTOR_CNT_EN
interface seq_pattern_detector_if #(
  parameter int PAT_LEN = 9
`ifdef SEQ_PATTERN_DETECTOR_CNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic data_valid;
  logic data;
  logic cfg_load;
  logic [PAT_LEN-1:0] cfg_pattern;
  logic [PAT_LEN-1:0] cfg_mask;
  logic cfg_overlap;
  logic match;
  logic armed;
`ifdef SEQ_PATTERN_DETECTOR_CNT_EN
  logic cnt_clr;
  logic [CNT_W-1:0] match_cnt;
  modport master (
    output data_valid, data, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, cnt_clr,
    input match, armed, match_cnt
  );
  modport slave (
    input data_valid, data, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, cnt_clr,
    output match, armed, match_cnt
  );
`else
  modport master (
    output data_valid, data, cfg_load, cfg_pattern, cfg_mask, cfg_overlap,
    input match, armed
  );
  modport slave (
    input data_valid, data, cfg_load, cfg_pattern, cfg_mask, cfg_overlap,
    output match, armed
  );
`endif
endinterface

// File: rtl/seq_det_match_cnt.sv
// seq_det_match_cnt: saturating event counter with synchronous clear that wins over increment
module seq_det_match_cnt #(
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic [CNT_W-1:0] cnt
);
  // count up to all-ones and hold there until cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: runtime-loaded masked serial pattern detector; SEQ_PATTERN_DETECTOR_CNT_EN adds a match counter
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = 9,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  seq_pattern_detector_if.slave bus
);
  localparam int FW = fill_w(PAT_LEN);
  if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_pat_len
    $error("seq_pattern_detector: PAT_LEN out of range");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("seq_pattern_detector: CNT_W out of range");
  end
  seq_det_state_e state_q;
  logic [PAT_LEN-1:0] hist_q, pat_q, mask_q, hist_nx;
  logic [FW-1:0] fill_q;
  logic ovl_q, match_q, accept, full, hit;
  // a hit is judged on the window as it will look after the incoming bit
  always_comb begin
    accept = bus.data_valid && !bus.cfg_load && state_q != UNCFG;
    hist_nx = {hist_q[PAT_LEN-2:0], bus.data};
    full = state_q == ARMED || (state_q == FILL && fill_q == FW'(PAT_LEN - 1));
    hit = accept && full && ((hist_nx ^ pat_q) & mask_q) == '0;
  end
  // config capture, history shift, fill tracking and the registered match pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNCFG;
      hist_q <= '0;
      fill_q <= '0;
      pat_q <= '0;
      mask_q <= '0;
      ovl_q <= 1'b0;
      match_q <= 1'b0;
    end else if (bus.cfg_load) begin
      state_q <= FILL;
      hist_q <= '0;
      fill_q <= '0;
      pat_q <= bus.cfg_pattern;
      mask_q <= bus.cfg_mask;
      ovl_q <= bus.cfg_overlap;
      match_q <= 1'b0;
    end else begin
      match_q <= hit;
      if (accept) begin
        hist_q <= hist_nx;
        if (hit && !ovl_q) begin
          state_q <= FILL;
          fill_q <= '0;
        end else if (state_q == FILL) begin
          state_q <= full ? ARMED : FILL;
          fill_q <= full ? fill_q : fill_q + 1'b1;
        end
      end
    end
  end
  assign bus.match = match_q;
  assign bus.armed = state_q == ARMED;
`ifdef SEQ_PATTERN_DETECTOR_CNT_EN
  seq_det_match_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(hit),
    .clr(bus.cnt_clr),
    .cnt(bus.match_cnt)
  );
`endif
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: directed stimulus on 9-bit and 3-bit detectors checked every cycle against a queue-based model
module tb_seq_pattern_detector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  seq_pattern_detector_if #(.PAT_LEN(9)) b9();
`ifdef SEQ_PATTERN_DETECTOR_CNT_EN
  seq_pattern_detector_if #(.PAT_LEN(3), .CNT_W(2)) b3();
`else
  seq_pattern_detector_if #(.PAT_LEN(3)) b3();
`endif
  seq_pattern_detector #(.PAT_LEN(9)) d9 (.clk(clk), .rst(rst), .bus(b9));
  seq_pattern_detector #(.PAT_LEN(3), .CNT_W(2)) d3 (.clk(clk), .rst(rst), .bus(b3));

  bit cfg9, cfg3, em9, em3, o9, o3;
  bit q9[$];
  bit q3[$];
  logic [31:0] p9, m9, p3, m3;
  int ec3 = 0;
  int mc9 = 0;
  int mc3 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // model: queue of bits accepted since the last load/flush; the newest n form the window
  task automatic mstep(input int n, input bit ld, input bit v, input bit d, input bit ov,
                       input logic [31:0] pi, input logic [31:0] mi,
                       inout bit cfg, inout bit q[$], inout logic [31:0] p, inout logic [31:0] m,
                       inout bit o, output bit hit);
    hit = 1'b0;
    if (ld) begin
      cfg = 1'b1;
      q.delete();
      p = pi;
      m = mi;
      o = ov;
    end else if (v && cfg) begin
      q.push_back(d);
      if (q.size() > n) void'(q.pop_front());
      if (q.size() == n) begin
        hit = 1'b1;
        for (int i = 0; i < n; i++)
          if (m[n-1-i] && q[i] != p[n-1-i]) hit = 1'b0;
        if (hit && !o) q.delete();
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      cfg9 = 1'b0; cfg3 = 1'b0; q9.delete(); q3.delete(); em9 = 1'b0; em3 = 1'b0; ec3 = 0;
    end else begin
      mstep(9, b9.cfg_load, b9.data_valid, b9.data, b9.cfg_overlap, 32'(b9.cfg_pattern),
            32'(b9.cfg_mask), cfg9, q9, p9, m9, o9, em9);
      mstep(3, b3.cfg_load, b3.data_valid, b3.data, b3.cfg_overlap, 32'(b3.cfg_pattern),
            32'(b3.cfg_mask), cfg3, q3, p3, m3, o3, em3);
`ifdef SEQ_PATTERN_DETECTOR_CNT_EN
      if (b3.cnt_clr) ec3 = 0;
      else if (em3 && ec3 < 3) ec3++;
`endif
    end
  end

  initial forever begin
    @(negedge clk);
    chk("match9", 32'(b9.match), 32'(em9));
    chk("armed9", 32'(b9.armed), 32'(cfg9 && q9.size() == 9));
    chk("match3", 32'(b3.match), 32'(em3));
    chk("armed3", 32'(b3.armed), 32'(cfg3 && q3.size() == 3));
`ifdef SEQ_PATTERN_DETECTOR_CNT_EN
    chk("cnt3", 32'(b3.match_cnt), 32'(ec3));
`endif
    mc9 += int'(b9.match);
    mc3 += int'(b3.match);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic load9(input logic [8:0] p, input logic [8:0] m, input bit o);
    b9.cfg_load = 1'b1; b9.cfg_pattern = p; b9.cfg_mask = m; b9.cfg_overlap = o;
    tick();
    b9.cfg_load = 1'b0;
  endtask
  task automatic load3(input logic [2:0] p, input logic [2:0] m, input bit o);
    b3.cfg_load = 1'b1; b3.cfg_pattern = p; b3.cfg_mask = m; b3.cfg_overlap = o;
    tick();
    b3.cfg_load = 1'b0;
  endtask
  task automatic send9(input bit d);
    b9.data_valid = 1'b1; b9.data = d;
    tick();
    b9.data_valid = 1'b0;
  endtask
  task automatic send3(input bit d);
    b3.data_valid = 1'b1; b3.data = d;
    tick();
    b3.data_valid = 1'b0;
  endtask
  task automatic stream9(input logic [31:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      send9(bits[i]);
      idle(gap);
    end
  endtask
  task automatic stream3(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send3(bits[i]);
  endtask

  initial begin
    int n0, n1;
    logic [8:0] v;
    b9.data_valid = 0; b9.data = 0; b9.cfg_load = 0; b9.cfg_pattern = '0; b9.cfg_mask = '0; b9.cfg_overlap = 0;
    b3.data_valid = 0; b3.data = 0; b3.cfg_load = 0; b3.cfg_pattern = '0; b3.cfg_mask = '0; b3.cfg_overlap = 0;
`ifdef SEQ_PATTERN_DETECTOR_CNT_EN
    b9.cnt_clr = 0; b3.cnt_clr = 0;
`endif
    idle(2);
    chk("rst_match9", 32'(b9.match), 0);
    chk("rst_armed9", 32'(b9.armed), 0);
    chk("rst_armed3", 32'(b3.armed), 0);
    @(negedge clk);
    rst = 1'b0;
    stream9(32'h1FF, 9, 0);
    chk("uncfg_armed9", 32'(b9.armed), 0);
    // fixed-pattern case: 011xxx110 against 0,1,1,1,0,1,1,1,0
    load9(9'b011000110, 9'b111000111, 1'b1);
    stream9(32'b01110111, 8, 0);
    chk("t1_armed_pre", 32'(b9.armed), 0);
    send9(1'b0);
    chk("t1_match", 32'(b9.match), 1);
    chk("t1_armed", 32'(b9.armed), 1);
    // reload while armed, then the same bits spread out by 1-3 idle cycles
    load9(9'b011000110, 9'b111000111, 1'b1);
    chk("reload_armed", 32'(b9.armed), 0);
    n0 = mc9;
    v = 9'b011101110;
    for (int i = 0; i < 9; i++) begin
      send9(v[8-i]);
      if (i < 8) idle(i % 3 + 1);
    end
    chk("t2_match", 32'(b9.match), 1);
    idle(2);
    chk("t2_count", mc9 - n0, 1);
    // all-don't-care mask: overlapping hits every bit once full, non-overlapping every 9 bits
    load9(9'h000, 9'h000, 1'b1);
    n0 = mc9;
    stream9(32'hABC, 12, 0);
    idle(1);
    chk("dc_ovl_count", mc9 - n0, 4);
    load9(9'h000, 9'h000, 1'b0);
    n0 = mc9;
    stream9(32'h5A5A5, 20, 0);
    idle(1);
    chk("dc_novl_count", mc9 - n0, 2);
    // 3-bit pattern 101 on 1,0,1,0,1
    load3(3'b101, 3'b111, 1'b1);
    n0 = mc3;
    stream3(32'b10101, 5);
    idle(1);
    chk("p3_ovl_count", mc3 - n0, 2);
    load3(3'b101, 3'b111, 1'b0);
    n0 = mc3;
    stream3(32'b10101, 5);
    idle(1);
    chk("p3_novl_count", mc3 - n0, 1);
    send3(1'b0);
    chk("p3_armed", 32'(b3.armed), 1);
    // asynchronous reset mid-stream, then bits without a reload
    load9(9'b011000110, 9'b111000111, 1'b1);
    stream9(32'b01110, 5, 0);
    rst = 1'b1;
    #1;
    chk("async_armed3", 32'(b3.armed), 0);
    chk("async_match9", 32'(b9.match), 0);
    @(negedge clk);
    rst = 1'b0;
    n0 = mc9;
    n1 = mc3;
    stream9(32'h0EE, 9, 0);
    stream3(32'b10101, 5);
    idle(1);
    chk("post_rst_count9", mc9 - n0, 0);
    chk("post_rst_count3", mc3 - n1, 0);
    chk("post_rst_armed9", 32'(b9.armed), 0);
    chk("post_rst_armed3", 32'(b3.armed), 0);
`ifdef SEQ_PATTERN_DETECTOR_CNT_EN
    // five hits saturate a 2-bit counter at 3; clear wins over a sixth increment
    load3(3'b000, 3'b000, 1'b1);
    stream3(32'b0000000, 7);
    idle(1);
    chk("cnt_sat", 32'(b3.match_cnt), 3);
    b3.cnt_clr = 1'b1;
    send3(1'b1);
    b3.cnt_clr = 1'b0;
    chk("cnt_clr", 32'(b3.match_cnt), 0);
    chk("cnt_clr_match", 32'(b3.match), 1);
`endif
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
